mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (A/B) arbiter in front of a single memory with fixed read/write latency.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port A has fixed priority.
module mem_arbiter #(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [11:0] a_add,
    input  logic [7:0]  a_din,
    output logic        a_ack,
    output logic [7:0]  a_dout,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [11:0] b_add,
    input  logic [7:0]  b_din,
    output logic        b_ack,
    output logic [7:0]  b_dout,
    output logic        m_cen,
    output logic        m_rd,
    output logic        m_wr,
    output logic [11:0] m_add,
    output logic [7:0]  m_din,
    input  logic [7:0]  m_dout,
    output logic        busy,
    output logic        last_gnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] RD_WAIT = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_WAIT = 3'(WR_LAT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        wr_q;
    logic        pick_b;
    logic        sel_wr;
    logic [11:0] sel_add;
    logic [7:0]  sel_din;
    logic [2:0]  lat_wait;
    logic        to_resp;

    always_comb begin
        pick_b = b_req;
        if (a_req && b_req) begin
`ifdef MEM_ARB_RR_EN
            pick_b = ~last_gnt;
`else
            pick_b = 1'b0;
`endif
        end
        sel_wr  = pick_b ? b_wr  : a_wr;
        sel_add = pick_b ? b_add : a_add;
        sel_din = pick_b ? b_din : a_din;
    end

    // The edge entering RESP is exactly RD_LAT edges after the grant edge, so read data is captured there.
    assign lat_wait = wr_q ? WR_WAIT : RD_WAIT;
    assign to_resp  = ((state == ISSUE) && (lat_wait == 3'd0)) ||
                      ((state == WAIT)  && (cnt == 3'd1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            wr_q     <= 1'b0;
            m_cen    <= 1'b1;
            m_rd     <= 1'b0;
            m_wr     <= 1'b0;
            m_add    <= 12'h000;
            m_din    <= 8'h00;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_dout   <= 8'h00;
            b_dout   <= 8'h00;
            last_gnt <= 1'b1;
        end else begin
            m_cen <= 1'b1;
            m_rd  <= 1'b0;
            m_wr  <= 1'b0;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        last_gnt <= pick_b;
                        wr_q     <= sel_wr;
                        m_add    <= sel_add;
                        m_din    <= sel_din;
                        m_cen    <= 1'b0;
                        m_rd     <= ~sel_wr;
                        m_wr     <= sel_wr;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_wait == 3'd0) begin
                        state <= RESP;
                    end else begin
                        cnt   <= lat_wait;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        cnt   <= 3'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (to_resp) begin
                a_ack <= ~last_gnt;
                b_ack <= last_gnt;
                if (!wr_q) begin
                    if (last_gnt) b_dout <= m_dout;
                    else          a_dout <= m_dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, corner sequences, and randomized traffic
// checked every cycle against a transaction-level timing model.
module tb_mem_arbiter;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          port;
        bit          wr;
        logic [11:0] add;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        int          exp_lat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_req, a_wr, a_ack, b_req, b_wr, b_ack;
    logic        m_cen, m_rd, m_wr, busy, last_gnt;
    logic [11:0] a_add, b_add, m_add;
    logic [7:0]  a_din, a_dout, b_din, b_dout, m_din, m_dout;

    logic        c_req, c_wr, c_ack, z_ack, m1_cen, m1_rd, m1_wr, busy1, last_gnt1;
    logic [11:0] c_add, m1_add;
    logic [7:0]  c_din, c_dout, z_dout, m1_din, m1_dout;

    mem_arbiter #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_add(a_add), .a_din(a_din), .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_wr(b_wr), .b_add(b_add), .b_din(b_din), .b_ack(b_ack), .b_dout(b_dout),
        .m_cen(m_cen), .m_rd(m_rd), .m_wr(m_wr), .m_add(m_add), .m_din(m_din), .m_dout(m_dout),
        .busy(busy), .last_gnt(last_gnt)
    );

    mem_arbiter #(.RD_LAT(1), .WR_LAT(WR_LAT)) u_lat1 (
        .clk(clk), .rst(rst),
        .a_req(c_req), .a_wr(c_wr), .a_add(c_add), .a_din(c_din), .a_ack(c_ack), .a_dout(c_dout),
        .b_req(1'b0), .b_wr(1'b0), .b_add(12'h000), .b_din(8'h00), .b_ack(z_ack), .b_dout(z_dout),
        .m_cen(m1_cen), .m_rd(m1_rd), .m_wr(m1_wr), .m_add(m1_add), .m_din(m1_din), .m_dout(m1_dout),
        .busy(busy1), .last_gnt(last_gnt1)
    );

    function automatic logic [7:0] init_val(input logic [11:0] a);
        return a[7:0] + {a[11:8], 4'h3};
    endfunction

    // Single-latency memory for the RD_LAT=1 instance: data is valid only during the strobe cycle.
    assign m1_dout = (!m1_cen && m1_rd) ? init_val(m1_add) : ~init_val(m1_add);

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem     [4096];
    logic [7:0]  ref_mem [4096];
    int          since = 100;
    logic [11:0] rd_addr = 12'h000;

    int          edge_n = 0;
    bit          act = 1'b0;
    int          g_edge = 0;
    int          g_lat = 0;
    bit          g_port = 1'b0;
    bit          g_wr = 1'b0;
    logic [11:0] g_add = 12'h000;
    logic [7:0]  g_din = 8'h00;
    bit          lg = 1'b1;
    logic [7:0]  ea = 8'h00, eb = 8'h00;
    logic [11:0] eadd = 12'h000;
    logic [7:0]  edin = 8'h00;
    bit          ack_log[$];

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act_v, exp_v);
        end
    endtask

    // Transaction-level model: a grant occupies edges g..g+lat+1; ack is visible after edge g+lat.
    task automatic model_edge();
        bit p;
        if (rst) begin
            act = 1'b0; lg = 1'b1; ea = 8'h00; eb = 8'h00; eadd = 12'h000; edin = 8'h00;
        end else begin
            if (act && edge_n == g_edge + g_lat) begin
                if (g_wr)        ref_mem[g_add] = g_din;
                else if (g_port) eb = ref_mem[g_add];
                else             ea = ref_mem[g_add];
            end
            if (act && edge_n == g_edge + g_lat + 1) begin
                act = 1'b0;
            end else if (!act && (a_req || b_req)) begin
                p      = (a_req && b_req) ? (RR ? !lg : 1'b0) : b_req;
                g_port = p;
                g_wr   = p ? b_wr  : a_wr;
                g_add  = p ? b_add : a_add;
                g_din  = p ? b_din : a_din;
                g_lat  = g_wr ? WR_LAT : RD_LAT;
                g_edge = edge_n;
                act    = 1'b1;
                lg     = p;
                eadd   = g_add;
                edin   = g_din;
            end
        end
    endtask

    task automatic mem_side();
        if (!m_cen && m_wr) mem[m_add] = m_din;
        if (!m_cen && m_rd) begin
            since   = 0;
            rd_addr = m_add;
        end else begin
            since++;
        end
        m_dout = (since == RD_LAT - 1) ? mem[rd_addr] : ~mem[rd_addr];
    endtask

    task automatic check_all();
        bit iss, ack_now;
        iss     = act && (edge_n == g_edge);
        ack_now = act && (edge_n == g_edge + g_lat);
        chk("busy",     32'(busy),          32'(act));
        chk("last_gnt", 32'(last_gnt),      32'(lg));
        chk("m_cen",    32'(m_cen),         32'(!iss));
        chk("m_rd",     32'(m_rd),          32'(iss && !g_wr));
        chk("m_wr",     32'(m_wr),          32'(iss && g_wr));
        chk("m_add",    32'(m_add),         32'(eadd));
        chk("m_din",    32'(m_din),         32'(edin));
        chk("a_ack",    32'(a_ack),         32'(ack_now && !g_port));
        chk("b_ack",    32'(b_ack),         32'(ack_now && g_port));
        chk("a_dout",   32'(a_dout),        32'(ea));
        chk("b_dout",   32'(b_dout),        32'(eb));
        chk("ack_excl", 32'(a_ack & b_ack), 32'd0);
        if (a_ack === 1'b1) ack_log.push_back(1'b0);
        if (b_ack === 1'b1) ack_log.push_back(1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        mem_side();
        check_all();
    endtask

    task automatic set_port(input bit p, input logic r, input logic w,
                            input logic [11:0] ad, input logic [7:0] d);
        if (p) begin b_req = r; b_wr = w; b_add = ad; b_din = d; end
        else   begin a_req = r; a_wr = w; a_add = ad; a_din = d; end
    endtask

    task automatic wait_ack(input bit p, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            n++;
            if ((p ? b_ack : a_ack) === 1'b1) ok = 1'b1;
        end
        if (!ok) chk("ack_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_txn(input txn_t t);
        int n;
        bit ok;
        step();
        set_port(t.port, 1'b1, t.wr, t.add, t.din);
        wait_ack(t.port, n, ok);
        chk({t.name, "_lat"}, 32'(n + 1), 32'(t.exp_lat));
        if (!t.wr) chk({t.name, "_dout"}, 32'(t.port ? b_dout : a_dout), 32'(t.exp_dout));
        if (t.port) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic rand_fields(output logic w, output logic [11:0] ad, output logic [7:0] d);
        w  = 1'($urandom_range(0, 1));
        ad = 12'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) ad = ad | 12'hC00;
        d  = 8'($urandom);
    endtask

    task automatic drive_port(input bit p);
        logic r, k, w;
        logic [11:0] ad;
        logic [7:0] d;
        bit upd;
        r = p ? b_req : a_req;
        k = p ? b_ack : a_ack;
        rand_fields(w, ad, d);
        if (r && k) begin
            r   = ($urandom_range(0, 3) == 0);
            upd = r;
        end else if (!r) begin
            r   = ($urandom_range(0, 2) == 0);
            upd = r;
        end else begin
            upd = act && (g_port == p) && ($urandom_range(0, 1) == 1);
        end
        if (p) begin b_req = r; if (upd) begin b_wr = w; b_add = ad; b_din = d; end end
        else   begin a_req = r; if (upd) begin a_wr = w; a_add = ad; a_din = d; end end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t tbl[6];
        int   n, nb, nrd;
        bit   ok, seen_iss;

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = init_val(12'(i));
            ref_mem[i] = init_val(12'(i));
        end
        m_dout = 8'h00;
        rst = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_add = 12'h000; a_din = 8'h00;
        b_req = 1'b0; b_wr = 1'b0; b_add = 12'h000; b_din = 8'h00;
        c_req = 1'b0; c_wr = 1'b0; c_add = 12'h000; c_din = 8'h00;
        repeat (2) step();
        rst = 1'b0;
        step();

        tbl[0] = '{"a_wr_805", 1'b0, 1'b1, 12'h805, 8'h3C, 8'h00, WR_LAT + 2};
        tbl[1] = '{"a_rd_805", 1'b0, 1'b0, 12'h805, 8'h00, 8'h3C, RD_LAT + 2};
        tbl[2] = '{"b_wr_123", 1'b1, 1'b1, 12'h123, 8'hA7, 8'h00, WR_LAT + 2};
        tbl[3] = '{"b_rd_123", 1'b1, 1'b0, 12'h123, 8'h00, 8'hA7, RD_LAT + 2};
        tbl[4] = '{"a_rd_123", 1'b0, 1'b0, 12'h123, 8'h00, 8'hA7, RD_LAT + 2};
        tbl[5] = '{"b_rd_c07", 1'b1, 1'b0, 12'hC07, 8'h00, 8'hCA, RD_LAT + 2};
        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset lands while a read sits in WAIT: dropped with no ack, then re-requested.
        step();
        set_port(1'b0, 1'b1, 1'b0, 12'h805, 8'h00);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_cen",   32'(m_cen),  32'd1);
        chk("rst_ack",   32'(a_ack),  32'd0);
        chk("rst_adout", 32'(a_dout), 32'd0);
        rst = 1'b0;
        wait_ack(1'b0, n, ok);
        chk("rereq_lat",  32'(n + 1),  32'(RD_LAT + 2));
        chk("rereq_dout", 32'(a_dout), 32'h3C);
        a_req = 1'b0;

        // Both ports hold read requests continuously.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack_log.delete();
        set_port(1'b0, 1'b1, 1'b0, 12'h805, 8'h00);
        set_port(1'b1, 1'b1, 1'b0, 12'h123, 8'h00);
        for (int k = 0; k < 80 && ack_log.size() < 4; k++) step();
        chk("dual_count", 32'(ack_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++)
            chk($sformatf("dual_order%0d", k), 32'(ack_log[k]), 32'(RR ? (k % 2) : 0));
        a_req = 1'b0;
        for (int k = 0; k < 20 && ack_log.size() < 5; k++) step();
        chk("dual_b_after_a", 32'(ack_log.size() >= 5 ? ack_log[4] : 1'b0), 32'd1);
        b_req = 1'b0;

        // B read of FFF while A inputs churn and B's own inputs change after the grant.
        step();
        set_port(1'b1, 1'b1, 1'b0, 12'hFFF, 8'h00);
        ok = 1'b0;
        seen_iss = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            step();
            a_add = ~a_add;
            a_wr  = ~a_wr;
            if (m_cen === 1'b0) begin
                seen_iss = 1'b1;
                chk("fff_issue_add", 32'(m_add), 32'hFFF);
            end
            if (b_ack === 1'b1) begin
                ok = 1'b1;
                chk("fff_dout", 32'(b_dout), 32'(init_val(12'hFFF)));
            end else begin
                b_add = 12'($urandom);
                b_din = 8'($urandom);
                b_wr  = ~b_wr;
            end
        end
        chk("fff_done", 32'(ok & seen_iss), 32'd1);
        b_req = 1'b0;
        a_wr  = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            step();
            drive_port(1'b0);
            drive_port(1'b1);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int k = 0; k < 20 && busy !== 1'b0; k++) step();
        chk("drain_idle", 32'(busy), 32'd0);

        // RD_LAT=1 instance: WAIT is skipped, so only ISSUE and RESP are busy.
        step();
        c_req = 1'b1; c_wr = 1'b0; c_add = 12'h456; c_din = 8'h77;
        n = 0; nb = 0; nrd = 0; ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            step();
            n++;
            if (busy1 === 1'b1) nb++;
            if (m1_rd === 1'b1 && m1_cen === 1'b0) nrd++;
            if (c_ack === 1'b1) begin
                ok = 1'b1;
                chk("lat1_lat",  32'(n + 1),  32'd3);
                chk("lat1_dout", 32'(c_dout), 32'(init_val(12'h456)));
            end
        end
        c_req = 1'b0;
        chk("lat1_done",      32'(ok),        32'd1);
        chk("lat1_busy",      32'(nb),        32'd2);
        chk("lat1_rd_pulses", 32'(nrd),       32'd1);
        chk("lat1_last_gnt",  32'(last_gnt1), 32'd0);
        chk("lat1_m_wr",      32'(m1_wr),     32'd0);
        chk("lat1_m_din",     32'(m1_din),    32'h77);
        chk("lat1_b_side",    32'({z_ack, z_dout}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
